// File: rtl/cdb_arbiter_if.sv
// Handshake bundle between the issue queues and the CDB arbiter.
// The slave side is the arbiter; the master side is the issue unit / queues.
interface cdb_arbiter_if;
  logic       int_ready;
  logic       ls_ready;
  logic       mult_ready;
  logic       div_ready;
  logic       int_done;
  logic       ls_done;
  logic       mult_done;
  logic       div_done;
  logic [1:0] cdb_sel;
  logic       cdb_sel_valid;
  logic       div_busy;

  modport master (
    output int_ready, ls_ready, mult_ready, div_ready,
    input  int_done, ls_done, mult_done, div_done,
    input  cdb_sel, cdb_sel_valid, div_busy
  );

  modport slave (
    input  int_ready, ls_ready, mult_ready, div_ready,
    output int_done, ls_done, mult_done, div_done,
    output cdb_sel, cdb_sel_valid, div_busy
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Issue-side CDB scheduler: grants a queue only when the CDB slot its result
// will occupy is free, and drives the registered CDB source select.
module cdb_arbiter #(
  parameter int unsigned MULT_LAT = 4,
  parameter int unsigned DIV_LAT  = 8
) (
  input logic         clk,
  input logic         reset,
  cdb_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;

  localparam logic [1:0] OWN_INT  = 2'd0;
  localparam logic [1:0] OWN_LS   = 2'd1;
  localparam logic [1:0] OWN_MULT = 2'd2;
  localparam logic [1:0] OWN_DIV  = 2'd3;

  // Slot k holds the CDB owner k cycles from now.
  logic [DIV_LAT-1:0] slot_v;
  logic [1:0]         slot_o     [DIV_LAT];
  logic [DIV_LAT-1:0] slot_v_nxt;
  logic [1:0]         slot_o_nxt [DIV_LAT];
  logic [DIV_LAT:0]   slot_v_ext;
  logic [1:0]         slot_o_ext [DIV_LAT+1];

  logic [CNT_W-1:0] div_cnt;
  logic [CNT_W-1:0] div_cnt_nxt;
  logic             div_busy_q;
  logic             rr;

  logic int_elig, ls_elig, mult_elig, div_elig;
  logic int_gnt, ls_gnt, mult_gnt, div_gnt;

  // Eligibility against the current reservation state.
  always_comb begin
    int_elig  = bus.int_ready  && !slot_v[1];
    ls_elig   = bus.ls_ready   && !slot_v[1];
    mult_elig = bus.mult_ready && !slot_v[MULT_LAT];
    div_elig  = bus.div_ready  && (div_cnt == '0);
  end

  // int and ls share slot 1; rr breaks the tie when both are eligible.
  always_comb begin
    int_gnt  = !reset && int_elig && (!ls_elig || !rr);
    ls_gnt   = !reset && ls_elig  && (!int_elig || rr);
    mult_gnt = !reset && mult_elig;
    div_gnt  = !reset && div_elig;
  end

  // Shift the reservation window down one slot and insert this cycle's grants.
  always_comb begin
    slot_v_ext = {1'b0, slot_v};
    for (int k = 0; k < DIV_LAT; k++) slot_o_ext[k] = slot_o[k];
    slot_o_ext[DIV_LAT] = OWN_INT;
    for (int k = 0; k < DIV_LAT; k++) begin
      slot_v_nxt[k] = slot_v_ext[k+1];
      slot_o_nxt[k] = slot_o_ext[k+1];
    end
    if (int_gnt || ls_gnt) begin
      slot_v_nxt[0] = 1'b1;
      slot_o_nxt[0] = int_gnt ? OWN_INT : OWN_LS;
    end
    if (mult_gnt) begin
      slot_v_nxt[MULT_LAT-1] = 1'b1;
      slot_o_nxt[MULT_LAT-1] = OWN_MULT;
    end
    if (div_gnt) begin
      slot_v_nxt[DIV_LAT-1] = 1'b1;
      slot_o_nxt[DIV_LAT-1] = OWN_DIV;
    end
  end

  always_comb begin
    div_cnt_nxt = div_cnt;
    if (div_gnt)              div_cnt_nxt = CNT_W'(DIV_LAT - 1);
    else if (div_cnt != '0)   div_cnt_nxt = div_cnt - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_v     <= '0;
      for (int k = 0; k < DIV_LAT; k++) slot_o[k] <= OWN_INT;
      div_cnt    <= '0;
      div_busy_q <= 1'b0;
      rr         <= 1'b0;
    end else begin
      slot_v     <= slot_v_nxt;
      for (int k = 0; k < DIV_LAT; k++) slot_o[k] <= slot_o_nxt[k];
      div_cnt    <= div_cnt_nxt;
      div_busy_q <= (div_cnt_nxt != '0);
      if (int_gnt)     rr <= 1'b1;
      else if (ls_gnt) rr <= 1'b0;
    end
  end

  assign bus.int_done      = int_gnt;
  assign bus.ls_done       = ls_gnt;
  assign bus.mult_done     = mult_gnt;
  assign bus.div_done      = div_gnt;
  assign bus.cdb_sel       = slot_o[0];
  assign bus.cdb_sel_valid = slot_v[0];
  assign bus.div_busy      = div_busy_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with MULT_LAT=4, DIV_LAT=8.
module tb_cdb_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  cdb_arbiter_if bus ();

  cdb_arbiter #(.MULT_LAT(4), .DIV_LAT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input logic i, input logic l, input logic m, input logic d);
    bus.int_ready  = i;
    bus.ls_ready   = l;
    bus.mult_ready = m;
    bus.div_ready  = d;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_ready(1, 1, 1, 1);
    tick();
    tick();
    set_ready(1, 1, 1, 1);
    check("rst_int_done",  32'(bus.int_done),  0);
    check("rst_ls_done",   32'(bus.ls_done),   0);
    check("rst_mult_done", 32'(bus.mult_done), 0);
    check("rst_div_done",  32'(bus.div_done),  0);
    check("rst_valid",     32'(bus.cdb_sel_valid), 0);
    check("rst_sel",       32'(bus.cdb_sel),   0);
    check("rst_div_busy",  32'(bus.div_busy),  0);
    set_ready(0, 0, 0, 0);
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    set_ready(0, 0, 0, 0);

    // 1: single int grant
    do_reset();
    set_ready(1, 0, 0, 0);
    check("t1_int_done", 32'(bus.int_done), 1);
    check("t1_valid0",   32'(bus.cdb_sel_valid), 0);
    tick();
    set_ready(0, 0, 0, 0);
    check("t1_valid1", 32'(bus.cdb_sel_valid), 1);
    check("t1_sel1",   32'(bus.cdb_sel), 0);
    tick();
    check("t1_valid2", 32'(bus.cdb_sel_valid), 0);

    // 2: int/ls alternation
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i < 6) set_ready(1, 1, 0, 0);
      else       set_ready(0, 0, 0, 0);
      if (i < 6) begin
        check("t2_int_done", 32'(bus.int_done), 32'((i % 2) == 0));
        check("t2_ls_done",  32'(bus.ls_done),  32'((i % 2) == 1));
      end
      if (i >= 1 && i <= 6) begin
        check("t2_valid", 32'(bus.cdb_sel_valid), 1);
        check("t2_sel",   32'(bus.cdb_sel), 32'((i - 1) % 2));
      end else begin
        check("t2_valid_idle", 32'(bus.cdb_sel_valid), 0);
      end
      tick();
    end

    // rr: after a lone int grant, ls wins the next tie
    do_reset();
    set_ready(1, 0, 0, 0);
    check("rr_int", 32'(bus.int_done), 1);
    tick();
    set_ready(1, 1, 0, 0);
    check("rr_tie_ls",  32'(bus.ls_done),  1);
    check("rr_tie_int", 32'(bus.int_done), 0);
    tick();
    set_ready(0, 1, 0, 0);
    check("rr_ls_only", 32'(bus.ls_done), 1);
    tick();
    set_ready(0, 0, 0, 0);
    check("rr_sel_ls", 32'(bus.cdb_sel), 1);

    // 3: mult reserves slot 1 at t+3, blocking int
    do_reset();
    set_ready(0, 0, 1, 0);
    check("t3_mult_done", 32'(bus.mult_done), 1);
    tick(); set_ready(0, 0, 0, 0);
    tick();
    tick(); set_ready(1, 0, 0, 0);
    check("t3_int_blocked", 32'(bus.int_done), 0);
    tick();
    check("t3_int_done", 32'(bus.int_done), 1);
    check("t3_sel_mult", 32'(bus.cdb_sel), 2);
    check("t3_val_mult", 32'(bus.cdb_sel_valid), 1);
    tick(); set_ready(0, 0, 0, 0);
    check("t3_sel_int", 32'(bus.cdb_sel), 0);
    check("t3_val_int", 32'(bus.cdb_sel_valid), 1);

    // 4: div held ready
    do_reset();
    for (int i = 0; i <= 16; i++) begin
      set_ready(0, 0, 0, 1);
      check("t4_div_done", 32'(bus.div_done), 32'(i == 0 || i == 8 || i == 16));
      check("t4_busy",     32'(bus.div_busy), 32'((i >= 1 && i <= 7) || (i >= 9 && i <= 15)));
      check("t4_valid",    32'(bus.cdb_sel_valid), 32'(i == 8 || i == 16));
      if (i == 8 || i == 16) check("t4_sel", 32'(bus.cdb_sel), 3);
      tick();
    end
    set_ready(0, 0, 0, 0);

    // 5: int, mult, div together
    do_reset();
    set_ready(1, 0, 1, 1);
    check("t5_int",  32'(bus.int_done),  1);
    check("t5_mult", 32'(bus.mult_done), 1);
    check("t5_div",  32'(bus.div_done),  1);
    tick();
    set_ready(0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      check("t5_valid", 32'(bus.cdb_sel_valid), 32'(i == 1 || i == 4 || i == 8));
      if (i == 1) check("t5_sel_int",  32'(bus.cdb_sel), 0);
      if (i == 4) check("t5_sel_mult", 32'(bus.cdb_sel), 2);
      if (i == 8) check("t5_sel_div",  32'(bus.cdb_sel), 3);
      tick();
    end

    // 6: reset mid-flight discards reservations
    do_reset();
    set_ready(0, 0, 1, 1);
    check("t6_mult", 32'(bus.mult_done), 1);
    check("t6_div",  32'(bus.div_done),  1);
    tick(); set_ready(0, 0, 0, 0);
    tick();
    reset = 1'b1;
    set_ready(1, 1, 1, 1);
    check("t6_rst_int_done", 32'(bus.int_done), 0);
    check("t6_rst_div_done", 32'(bus.div_done), 0);
    tick();
    reset = 1'b0;
    set_ready(0, 0, 0, 0);
    for (int i = 3; i <= 11; i++) begin
      check("t6_valid", 32'(bus.cdb_sel_valid), 0);
      check("t6_busy",  32'(bus.div_busy), 0);
      check("t6_sel",   32'(bus.cdb_sel), 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
